sme_driver: RTL and testbench

Host-side transmitter for the string-matching engine's character-stream protocol. Holds a string buffer and a pattern buffer loaded over a simple write port. On `start` it streams the string and then the pattern to the engine, one character per cycle, qualified by `isstring`/`ispattern`. It then waits for the engine's `valid` pulse, captures `match`/`match_index`, and reports completion to the host with a one-cycle `done`.

---
 rtl/sme_driver.sv | 243 ++++++++++++++++++++++++
 tb/tb_sme_driver.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_driver.sv
// Host-side transmitter for the string-matching engine: buffers a string
// and a pattern, streams them out one character per cycle, then waits for
// the engine result and reports it with a one-cycle done pulse.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data  buffer write port (sel 0 = string, 1 = pattern)
//   str_len, pat_len, keep_str, start  transaction request (sampled at start)
//   busy, done, result_match, result_index, err, timeout  host status
//   chardata, isstring, ispattern  character stream to the engine
//   sme_valid, sme_match, sme_match_index  engine result
module sme_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       keep_str,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       result_match,
    output logic [4:0] result_index,
    output logic       err,
    output logic       timeout,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index
);

    localparam logic [5:0] STR_LIM = 6'(STR_MAX);
    localparam logic [3:0] PAT_LIM = 4'(PAT_MAX);
    localparam logic [9:0] TO_CNT  = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SEND_STR, SEND_PAT, WAIT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  str_idx_q, str_idx_d;
    logic [2:0]  pat_idx_q, pat_idx_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [5:0]  str_len_q, str_len_d;
    logic [3:0]  pat_len_q, pat_len_d;
    logic        str_ok_q, str_ok_d;
    logic        err_pend_q, err_pend_d;
    logic        to_pend_q, to_pend_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
    logic        res_match_q, res_match_d;
    logic [4:0]  res_index_q, res_index_d;
    logic [7:0]  chardata_q, chardata_d;
    logic        isstring_q, isstring_d;
    logic        ispattern_q, ispattern_d;

    logic [7:0]  str_buf_q [STR_MAX];
    logic [7:0]  pat_buf_q [PAT_MAX];

    logic        wr_ok;
    logic        need_str;
    logic        len_bad;
    logic [4:0]  str_nxt;
    logic [2:0]  pat_nxt;

    // Buffers only change while idle and not starting, so a transmit
    // never sees a character change under it.
    assign wr_ok   = wr_en && (state_q == IDLE) && !start;
    assign str_nxt = str_idx_q + 5'd1;
    assign pat_nxt = pat_idx_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        str_idx_d   = str_idx_q;
        pat_idx_d   = pat_idx_q;
        cnt_d       = cnt_q;
        str_len_d   = str_len_q;
        pat_len_d   = pat_len_q;
        str_ok_d    = str_ok_q;
        err_pend_d  = err_pend_q;
        to_pend_d   = to_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        timeout_d   = 1'b0;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        chardata_d  = chardata_q;
        isstring_d  = isstring_q;
        ispattern_d = ispattern_q;
        // A keep_str request only skips the string if the engine holds one.
        need_str    = !(keep_str && str_ok_q);
        len_bad     = (pat_len == 4'd0) || (pat_len > PAT_LIM) ||
                      (need_str && ((str_len == 6'd0) || (str_len > STR_LIM)));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    str_len_d = str_len;
                    pat_len_d = pat_len;
                    str_idx_d = 5'd0;
                    pat_idx_d = 3'd0;
                    if (len_bad) begin
                        err_pend_d = 1'b1;
                        state_d    = DONE;
                    end else if (need_str) begin
                        chardata_d = str_buf_q[0];
                        isstring_d = 1'b1;
                        state_d    = SEND_STR;
                    end else begin
                        chardata_d  = pat_buf_q[0];
                        ispattern_d = 1'b1;
                        state_d     = SEND_PAT;
                    end
                end
            end
            SEND_STR: begin
                if ({1'b0, str_idx_q} == str_len_q - 6'd1) begin
                    str_ok_d    = 1'b1;
                    chardata_d  = pat_buf_q[0];
                    isstring_d  = 1'b0;
                    ispattern_d = 1'b1;
                    state_d     = SEND_PAT;
                end else begin
                    str_idx_d  = str_nxt;
                    chardata_d = str_buf_q[str_nxt];
                end
            end
            SEND_PAT: begin
                if ({1'b0, pat_idx_q} == pat_len_q - 4'd1) begin
                    chardata_d  = 8'd0;
                    ispattern_d = 1'b0;
                    cnt_d       = 10'd0;
                    state_d     = WAIT;
                end else begin
                    pat_idx_d  = pat_nxt;
                    chardata_d = pat_buf_q[pat_nxt];
                end
            end
            WAIT: begin
                if (sme_valid) begin
                    res_match_d = sme_match;
                    res_index_d = sme_match_index;
                    state_d     = DONE;
                end else if (cnt_q == TO_CNT) begin
                    res_match_d = 1'b0;
                    res_index_d = 5'd0;
                    to_pend_d   = 1'b1;
                    str_ok_d    = 1'b0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                err_d      = err_pend_q;
                timeout_d  = to_pend_q;
                if (err_pend_q) begin
                    str_ok_d = 1'b0;
                end
                err_pend_d = 1'b0;
                to_pend_d  = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            str_idx_q   <= 5'd0;
            pat_idx_q   <= 3'd0;
            cnt_q       <= 10'd0;
            str_len_q   <= 6'd0;
            pat_len_q   <= 4'd0;
            str_ok_q    <= 1'b0;
            err_pend_q  <= 1'b0;
            to_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= 5'd0;
            chardata_q  <= 8'd0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            str_idx_q   <= str_idx_d;
            pat_idx_q   <= pat_idx_d;
            cnt_q       <= cnt_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            str_ok_q    <= str_ok_d;
            err_pend_q  <= err_pend_d;
            to_pend_q   <= to_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            chardata_q  <= chardata_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_sel) begin
            str_buf_q[wr_addr] <= wr_data;
        end
        if (wr_ok && wr_sel) begin
            pat_buf_q[wr_addr[2:0]] <= wr_data;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign timeout      = timeout_q;
    assign result_match = res_match_q;
    assign result_index = res_index_q;
    assign chardata     = chardata_q;
    assign isstring     = isstring_q;
    assign ispattern    = ispattern_q;

endmodule

// File: tb/tb_sme_driver.sv
// Directed self-checking bench for sme_driver (TIMEOUT reduced to 15).
// Each task drives one scenario and checks outputs 1 time unit after posedge.
module tb_sme_driver;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       wr_sel;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       keep_str;
    logic       start;
    logic       busy;
    logic       done;
    logic       result_match;
    logic [4:0] result_index;
    logic       err;
    logic       timeout;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       sme_match;
    logic [4:0] sme_match_index;

    int checks;
    int failures;

    sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(15)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .str_len         (str_len),
        .pat_len         (pat_len),
        .keep_str        (keep_str),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .result_match    (result_match),
        .result_index    (result_index),
        .err             (err),
        .timeout         (timeout),
        .chardata        (chardata),
        .isstring        (isstring),
        .ispattern       (ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input logic sel, input logic [4:0] a,
                             input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic ks, input logic [5:0] sl,
                            input logic [3:0] pl);
        start = 1'b1; keep_str = ks; str_len = sl; pat_len = pl;
        tick();
        start = 1'b0;
    endtask

    // Pulse the engine result for one edge, then step to the done cycle.
    task automatic answer(input logic m, input logic [4:0] idx);
        sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
        tick();
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, err, timeout, result_match, result_index,
             chardata, isstring, ispattern} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b to=%b m=%b idx=%0d ch=%h s=%b p=%b want all 0",
                     busy, done, err, timeout, result_match, result_index,
                     chardata, isstring, ispattern);
        end
    endtask

    task automatic test_full();
        logic [7:0] s [5];
        logic [7:0] p [2];
        s = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64};
        p = '{8'h63, 8'h64};
        for (int i = 0; i < 5; i++) write_buf(1'b0, 5'(i), s[i]);
        for (int i = 0; i < 2; i++) write_buf(1'b1, 5'(i), p[i]);
        do_start(1'b0, 6'd5, 4'd2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL full_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({isstring, ispattern, chardata} !== {2'b10, s[i]}) begin
                failures++;
                $display("FAIL full_str%0d: got s=%b p=%b ch=%h want s=1 p=0 ch=%h",
                         i, isstring, ispattern, chardata, s[i]);
            end
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({isstring, ispattern, chardata} !== {2'b01, p[j]}) begin
                failures++;
                $display("FAIL full_pat%0d: got s=%b p=%b ch=%h want s=0 p=1 ch=%h",
                         j, isstring, ispattern, chardata, p[j]);
            end
            tick();
        end
        checks++;
        if ({isstring, ispattern, chardata, busy, done} !== 12'b00_00000000_10) begin
            failures++;
            $display("FAIL full_wait: got s=%b p=%b ch=%h busy=%b done=%b want 0,0,00,1,0",
                     isstring, ispattern, chardata, busy, done);
        end
        tick();
        tick();
        tick();
        sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd3;
        tick();
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL full_done_early: got %b want 0", done);
        end
        tick();
        checks++;
        if ({done, busy, result_match, result_index, err, timeout}
            !== {1'b1, 1'b0, 1'b1, 5'd3, 2'b00}) begin
            failures++;
            $display("FAIL full_result: got done=%b busy=%b m=%b idx=%0d err=%b to=%b want 1,0,1,3,0,0",
                     done, busy, result_match, result_index, err, timeout);
        end
        tick();
        checks++;
        if ({done, result_match, result_index} !== {1'b0, 1'b1, 5'd3}) begin
            failures++;
            $display("FAIL full_hold: got done=%b m=%b idx=%0d want 0,1,3",
                     done, result_match, result_index);
        end
    endtask

    task automatic test_reuse();
        write_buf(1'b1, 5'd0, 8'h5E);
        write_buf(1'b1, 5'd1, 8'h61);
        do_start(1'b1, 6'd0, 4'd2);
        checks++;
        if ({isstring, ispattern, chardata} !== {2'b01, 8'h5E}) begin
            failures++;
            $display("FAIL reuse_pat0: got s=%b p=%b ch=%h want 0,1,5e",
                     isstring, ispattern, chardata);
        end
        tick();
        checks++;
        if ({isstring, ispattern, chardata} !== {2'b01, 8'h61}) begin
            failures++;
            $display("FAIL reuse_pat1: got s=%b p=%b ch=%h want 0,1,61",
                     isstring, ispattern, chardata);
        end
        tick();
        answer(1'b1, 5'd0);
        checks++;
        if ({done, result_match, result_index} !== {1'b1, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL reuse_result: got done=%b m=%b idx=%0d want 1,1,0",
                     done, result_match, result_index);
        end
    endtask

    // Start held during the done cycle is sampled once the block is idle.
    task automatic test_back_to_back();
        do_start(1'b1, 6'd0, 4'd1);
        checks++;
        if ({busy, ispattern, chardata} !== {2'b11, 8'h5E}) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b p=%b ch=%h want 1,1,5e",
                     busy, ispattern, chardata);
        end
        tick();
        answer(1'b0, 5'd7);
        checks++;
        if ({done, result_match, result_index} !== {1'b1, 1'b0, 5'd7}) begin
            failures++;
            $display("FAIL b2b_result: got done=%b m=%b idx=%0d want 1,0,7",
                     done, result_match, result_index);
        end
        tick();
    endtask

    task automatic test_illegal();
        do_start(1'b0, 6'd5, 4'd0);
        checks++;
        if ({busy, done, isstring, ispattern} !== 4'b1000) begin
            failures++;
            $display("FAIL err_first: got busy=%b done=%b s=%b p=%b want 1,0,0,0",
                     busy, done, isstring, ispattern);
        end
        tick();
        checks++;
        if ({done, err, timeout, busy, isstring, ispattern, result_index}
            !== {6'b110000, 5'd7}) begin
            failures++;
            $display("FAIL err_done: got done=%b err=%b to=%b busy=%b s=%b p=%b idx=%0d want 1,1,0,0,0,0,7",
                     done, err, timeout, busy, isstring, ispattern, result_index);
        end
        tick();
        checks++;
        if ({done, err} !== 2'b00) begin
            failures++;
            $display("FAIL err_clear: got done=%b err=%b want 0,0", done, err);
        end
        // Write in the start cycle, start held while busy, write in SEND_PAT.
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd0; wr_data = 8'h58;
        do_start(1'b0, 6'd1, 4'd2);
        start = 1'b1; str_len = 6'd3; pat_len = 4'd1;
        wr_en = 1'b0;
        checks++;
        if ({isstring, chardata} !== {1'b1, 8'h61}) begin
            failures++;
            $display("FAIL busy_str: got s=%b ch=%h want 1,61", isstring, chardata);
        end
        tick();
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd1; wr_data = 8'h51;
        checks++;
        if ({ispattern, chardata} !== {1'b1, 8'h5E}) begin
            failures++;
            $display("FAIL busy_pat0: got p=%b ch=%h want 1,5e", ispattern, chardata);
        end
        tick();
        wr_en = 1'b0;
        tick();
        checks++;
        if ({busy, isstring, ispattern, done} !== 4'b1000) begin
            failures++;
            $display("FAIL busy_ignore: got busy=%b s=%b p=%b done=%b want 1,0,0,0",
                     busy, isstring, ispattern, done);
        end
        start = 1'b0;
        answer(1'b1, 5'd31);
        checks++;
        if ({done, result_match, result_index} !== {1'b1, 1'b1, 5'd31}) begin
            failures++;
            $display("FAIL busy_result: got done=%b m=%b idx=%0d want 1,1,31",
                     done, result_match, result_index);
        end
        tick();
        do_start(1'b1, 6'd0, 4'd2);
        checks++;
        if ({isstring, ispattern, chardata} !== {2'b01, 8'h5E}) begin
            failures++;
            $display("FAIL wr_drop0: got s=%b p=%b ch=%h want 0,1,5e",
                     isstring, ispattern, chardata);
        end
        tick();
        checks++;
        if ({ispattern, chardata} !== {1'b1, 8'h61}) begin
            failures++;
            $display("FAIL wr_drop1: got p=%b ch=%h want 1,61", ispattern, chardata);
        end
        tick();
        answer(1'b0, 5'd2);
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        do_start(1'b1, 6'd0, 4'd1);
        for (int n = 0; n < 17; n++) begin
            tick();
            if (done !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL to_early: got %0d early done cycles want 0", early);
        end
        tick();
        checks++;
        if ({done, timeout, err, busy, result_match, result_index}
            !== {4'b1100, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL to_done: got done=%b to=%b err=%b busy=%b m=%b idx=%0d want 1,1,0,0,0,0",
                     done, timeout, err, busy, result_match, result_index);
        end
        tick();
        checks++;
        if ({done, timeout} !== 2'b00) begin
            failures++;
            $display("FAIL to_clear: got done=%b to=%b want 0,0", done, timeout);
        end
        do_start(1'b1, 6'd2, 4'd1);
        checks++;
        if ({isstring, chardata} !== {1'b1, 8'h61}) begin
            failures++;
            $display("FAIL to_resend: got s=%b ch=%h want 1,61", isstring, chardata);
        end
        // An engine strobe during transmit must be ignored.
        sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd4;
        tick();
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
        tick();
        tick();
        checks++;
        if ({busy, done, result_match, result_index} !== {3'b100, 5'd0}) begin
            failures++;
            $display("FAIL to_valid_ignored: got busy=%b done=%b m=%b idx=%0d want 1,0,0,0",
                     busy, done, result_match, result_index);
        end
        answer(1'b1, 5'd9);
        checks++;
        if ({done, result_match, result_index} !== {2'b11, 5'd9}) begin
            failures++;
            $display("FAIL to_next_result: got done=%b m=%b idx=%0d want 1,1,9",
                     done, result_match, result_index);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        do_start(1'b0, 6'd5, 4'd2);
        tick();
        tick();
        checks++;
        if (chardata !== 8'h20) begin
            failures++;
            $display("FAIL rst_third: got ch=%h want 20", chardata);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, err, timeout, result_match, result_index,
             chardata, isstring, ispattern} !== 22'd0) begin
            failures++;
            $display("FAIL rst_mid: got busy=%b done=%b m=%b idx=%0d ch=%h s=%b p=%b want all 0",
                     busy, done, result_match, result_index, chardata,
                     isstring, ispattern);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            if (done !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rst_no_done: got %0d done cycles want 0", dones);
        end
        do_start(1'b1, 6'd5, 4'd2);
        checks++;
        if ({isstring, chardata} !== {1'b1, 8'h61}) begin
            failures++;
            $display("FAIL rst_resend: got s=%b ch=%h want 1,61", isstring, chardata);
        end
        for (int n = 0; n < 7; n++) tick();
        answer(1'b1, 5'd3);
        checks++;
        if ({done, result_match, result_index} !== {2'b11, 5'd3}) begin
            failures++;
            $display("FAIL rst_result: got done=%b m=%b idx=%0d want 1,1,3",
                     done, result_match, result_index);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'd0;
        str_len = 6'd0; pat_len = 4'd0; keep_str = 1'b0; start = 1'b0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0;
        test_reset();
        test_full();
        test_reuse();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
